// File: rtl/sweep_arbiter.sv
// sweep_arbiter: grants one of two sweep requesters the shared address counter and turns its count into pixel writes.
// Build option SWEEP_ROUND_ROBIN_EN: ties alternate after every sweep; without it req0 always wins ties.
module sweep_arbiter #(
  parameter int ADDR_W = 17
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] len0_i,
  input  logic [ADDR_W-1:0] len1_i,
  input  logic [ADDR_W-1:0] base0_i,
  input  logic [ADDR_W-1:0] base1_i,
  output logic              grant0_o,
  output logic              grant1_o,
  output logic              done0_o,
  output logic              done1_o,
  output logic              busy_o,
  output logic              cnt_start_o,
  output logic [ADDR_W-1:0] cnt_limit_o,
  input  logic              cnt_counting_i,
  input  logic [ADDR_W-1:0] cnt_result_i,
  output logic              plot_o,
  output logic [ADDR_W-1:0] plot_addr_o,
  output logic              plot_owner_o
);

  typedef enum logic [2:0] {IDLE, START, ARM, RUN, DONE} state_t;

  state_t            state_q;
  logic [1:0]        req_q;
  logic [1:0]        grant_q;
  logic [1:0]        done_q;
  logic              start_q;
  logic              owner_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] base_q;
  logic              win_d;
  logic [ADDR_W-1:0] len_d;
  logic [ADDR_W-1:0] base_d;

`ifdef SWEEP_ROUND_ROBIN_EN
  logic ptr_q;

  always_comb win_d = (req_q[0] & req_q[1]) ? ptr_q : ~req_q[0];
`else
  always_comb win_d = ~req_q[0];
`endif

  always_comb begin
    len_d  = win_d ? len1_i : len0_i;
    base_d = win_d ? base1_i : base0_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      req_q   <= 2'b00;
      grant_q <= 2'b00;
      done_q  <= 2'b00;
      start_q <= 1'b0;
      owner_q <= 1'b0;
      len_q   <= '0;
      base_q  <= '0;
`ifdef SWEEP_ROUND_ROBIN_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      // The finishing owner's request is dropped for one cycle so a still-high
      // level only counts as a new request once the arbiter is back in IDLE.
      req_q   <= {req1_i & ~done_q[1], req0_i & ~done_q[0]};
      start_q <= 1'b0;
      done_q  <= 2'b00;
      case (state_q)
        IDLE: begin
          if (!cnt_counting_i && (req_q != 2'b00)) begin
            owner_q <= win_d;
            len_q   <= len_d;
            base_q  <= base_d;
            grant_q <= win_d ? 2'b10 : 2'b01;
            if (len_d == '0) begin
              state_q <= DONE;
              done_q  <= win_d ? 2'b10 : 2'b01;
            end else begin
              state_q <= START;
              start_q <= 1'b1;
            end
          end
        end
        START: state_q <= ARM;
        ARM: begin
          if (cnt_counting_i) state_q <= RUN;
        end
        RUN: begin
          if (!cnt_counting_i) begin
            state_q <= DONE;
            done_q  <= owner_q ? 2'b10 : 2'b01;
          end
        end
        DONE: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
`ifdef SWEEP_ROUND_ROBIN_EN
          ptr_q   <= ~owner_q;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant0_o     = grant_q[0];
  assign grant1_o     = grant_q[1];
  assign done0_o      = done_q[0];
  assign done1_o      = done_q[1];
  assign cnt_start_o  = start_q;
  assign busy_o       = (state_q != IDLE);
  assign cnt_limit_o  = (state_q != IDLE) ? len_q : '0;
  assign plot_o       = cnt_counting_i & ((state_q == ARM) | (state_q == RUN));
  assign plot_addr_o  = plot_o ? (base_q + cnt_result_i) : '0;
  assign plot_owner_o = owner_q;

endmodule

// File: tb/tb_sweep_arbiter.sv
// Bench for sweep_arbiter: directed sweeps plus a randomized two-requester run against a transaction-level model.
// The shared counter is modelled here; it has no reset, like the real one.
module tb_sweep_arbiter;
  localparam int AW = 17;
`ifdef SWEEP_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic req0, req1;
  logic [AW-1:0] len0, len1, base0, base1;
  logic grant0, grant1, done0, done1, busy, cnt_start, plot, plot_owner;
  logic [AW-1:0] cnt_limit, plot_addr, cnt_result;
  logic cnt_counting;
  int total = 0;
  int bad = 0;
  int cnt_rem = 0;
  logic [AW-1:0] cnt_val = '0;

  always #5 clk = ~clk;

  // Counter: counts 0..limit-1 starting the cycle after the start pulse.
  always @(posedge clk) begin
    if (cnt_start) begin
      cnt_rem <= int'(cnt_limit);
      cnt_val <= '0;
    end else if (cnt_rem != 0) begin
      cnt_rem <= cnt_rem - 1;
      cnt_val <= cnt_val + 1'b1;
    end
  end
  assign cnt_counting = (cnt_rem != 0);
  assign cnt_result   = cnt_val;

  sweep_arbiter #(.ADDR_W(AW)) dut (
    .clk_i(clk), .reset_i(rst),
    .req0_i(req0), .req1_i(req1),
    .len0_i(len0), .len1_i(len1), .base0_i(base0), .base1_i(base1),
    .grant0_o(grant0), .grant1_o(grant1), .done0_o(done0), .done1_o(done1),
    .busy_o(busy), .cnt_start_o(cnt_start), .cnt_limit_o(cnt_limit),
    .cnt_counting_i(cnt_counting), .cnt_result_i(cnt_result),
    .plot_o(plot), .plot_addr_o(plot_addr), .plot_owner_o(plot_owner)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic wait_cnt_idle();
    for (int i = 0; i < 64 && cnt_counting; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    len0 = '0; len1 = '0; base0 = '0; base1 = '0;
    step(); step();
    total++; if ({grant1, grant0} !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b want=00", {grant1, grant0}); end
    total++; if ({done1, done0} !== 2'b00) begin bad++; $display("FAIL reset_done got=%b want=00", {done1, done0}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (cnt_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b want=0", cnt_start); end
    total++; if (cnt_limit !== '0) begin bad++; $display("FAIL reset_limit got=%0d want=0", cnt_limit); end
    total++; if (plot !== 1'b0) begin bad++; $display("FAIL reset_plot got=%b want=0", plot); end
    total++; if (plot_addr !== '0) begin bad++; $display("FAIL reset_addr got=%0d want=0", plot_addr); end
    total++; if (plot_owner !== 1'b0) begin bad++; $display("FAIL reset_owner got=%b want=0", plot_owner); end
    rst = 1'b0;
    step();
  endtask

  // Single requester, counter idle: grant at +2, start at +2, plots +3..len+2, done at len+4 (or +2 for len 0).
  task automatic test_single_sweep(input bit who, input logic [AW-1:0] base, input logic [AW-1:0] len, input string tag);
    int done_k;
    logic [1:0] eg, ed, oh;
    logic [AW-1:0] ea;
    bit ep;
    wait_cnt_idle();
    req0 = 1'b0; req1 = 1'b0;
    step(); step();
    if (who) begin len1 = len; base1 = base; req1 = 1'b1; end
    else     begin len0 = len; base0 = base; req0 = 1'b1; end
    oh = who ? 2'b10 : 2'b01;
    done_k = (len == '0) ? 2 : int'(len) + 4;
    for (int k = 1; k <= done_k + 2; k++) begin
      step();
      eg = (k >= 2 && k <= done_k) ? oh : 2'b00;
      ed = (k == done_k) ? oh : 2'b00;
      ep = (len != '0) && (k >= 3) && (k <= int'(len) + 2);
      total++; if ({grant1, grant0} !== eg) begin bad++; $display("FAIL %s_grant k=%0d got=%b want=%b", tag, k, {grant1, grant0}, eg); end
      total++; if ({done1, done0} !== ed) begin bad++; $display("FAIL %s_done k=%0d got=%b want=%b", tag, k, {done1, done0}, ed); end
      total++; if (cnt_start !== ((len != '0) && k == 2)) begin bad++; $display("FAIL %s_start k=%0d got=%b", tag, k, cnt_start); end
      total++; if (plot !== ep) begin bad++; $display("FAIL %s_plot k=%0d got=%b want=%b", tag, k, plot, ep); end
      if (ep) begin
        ea = AW'(int'(base) + k - 3);
        total++; if (plot_addr !== ea) begin bad++; $display("FAIL %s_addr k=%0d got=%0d want=%0d", tag, k, plot_addr, ea); end
      end
      total++; if (cnt_limit !== ((eg != 2'b00) ? len : '0)) begin bad++; $display("FAIL %s_limit k=%0d got=%0d", tag, k, cnt_limit); end
      total++; if (busy !== (eg != 2'b00)) begin bad++; $display("FAIL %s_busy k=%0d got=%b", tag, k, busy); end
      if (eg != 2'b00) begin
        total++; if (plot_owner !== who) begin bad++; $display("FAIL %s_owner k=%0d got=%b want=%b", tag, k, plot_owner, who); end
      end
      if (k == done_k) begin req0 = 1'b0; req1 = 1'b0; end
    end
  endtask

  task automatic test_tie();
    int order[$];
    int dn[2];
    bit pg0, pg1;
    int got;
    wait_cnt_idle(); do_reset();
    dn[0] = 0; dn[1] = 0; pg0 = 0; pg1 = 0;
    len0 = 3; len1 = 3; base0 = 10; base1 = 200;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 100 && (dn[0] < 2 || dn[1] < 2); k++) begin
      step();
      if (grant0 && !pg0) order.push_back(0);
      if (grant1 && !pg1) order.push_back(1);
      pg0 = grant0; pg1 = grant1;
      if (done0) begin dn[0]++; if (dn[0] == 2) req0 = 1'b0; end
      if (done1) begin dn[1]++; if (dn[1] == 2) req1 = 1'b0; end
    end
    total++; if (order.size() != 4) begin bad++; $display("FAIL tie_count got=%0d want=4", order.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < order.size()) ? order[i] : -1;
      total++; if (got != i % 2) begin bad++; $display("FAIL tie_order idx=%0d got=%0d want=%0d", i, got, i % 2); end
    end
  endtask

  task automatic test_priority();
    int order[$];
    bit seen, pg0, pg1;
    int got, first, ndone;
    wait_cnt_idle(); do_reset();
    len0 = 2; base0 = 50; req0 = 1'b1; seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      step();
      if (done0) begin seen = 1; req0 = 1'b0; end
    end
    total++; if (!seen) begin bad++; $display("FAIL prio_first_done got=none want=done0"); end
    step(); step();
    len0 = 1; len1 = 1; base0 = 60; base1 = 70;
    req0 = 1'b1; req1 = 1'b1; pg0 = 0; pg1 = 0; ndone = 0;
    for (int k = 0; k < 60 && ndone < 2; k++) begin
      step();
      if (grant0 && !pg0) order.push_back(0);
      if (grant1 && !pg1) order.push_back(1);
      pg0 = grant0; pg1 = grant1;
      if (done0) begin req0 = 1'b0; ndone++; end
      if (done1) begin req1 = 1'b0; ndone++; end
    end
    first = RR ? 1 : 0;
    got = (order.size() > 0) ? order[0] : -1;
    total++; if (got != first) begin bad++; $display("FAIL prio_tie_winner got=%0d want=%0d", got, first); end
    got = (order.size() > 1) ? order[1] : -1;
    total++; if (got != 1 - first) begin bad++; $display("FAIL prio_tie_loser got=%0d want=%0d", got, 1 - first); end
  endtask

  task automatic test_reset_mid();
    bit hit;
    int starts, plots, dones;
    logic [AW-1:0] ea;
    wait_cnt_idle(); do_reset();
    base0 = 17'd5000; len0 = 20; req0 = 1'b1; hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      step();
      if (plot && cnt_result == 7) hit = 1;
    end
    total++; if (!hit) begin bad++; $display("FAIL rmid_reach got=no want=result7"); end
    rst = 1'b1; req0 = 1'b0;
    #1;
    total++; if ({grant1, grant0, done1, done0} !== 4'b0000) begin bad++; $display("FAIL rmid_gd got=%b want=0000", {grant1, grant0, done1, done0}); end
    total++; if ({busy, cnt_start, plot} !== 3'b000) begin bad++; $display("FAIL rmid_ctl got=%b want=000", {busy, cnt_start, plot}); end
    total++; if (cnt_limit !== '0 || plot_addr !== '0) begin bad++; $display("FAIL rmid_bus got=%0d/%0d want=0/0", cnt_limit, plot_addr); end
    step();
    rst = 1'b0; req0 = 1'b1;
    starts = 0; plots = 0; dones = 0;
    for (int k = 0; k < 80 && dones == 0; k++) begin
      step();
      if (cnt_start) begin
        starts++;
        total++; if (cnt_counting !== 1'b0) begin bad++; $display("FAIL rmid_holdoff got=start_while_counting want=wait"); end
      end
      if (plot) begin
        ea = AW'(5000 + plots);
        total++; if (plot_addr !== ea) begin bad++; $display("FAIL rmid_addr got=%0d want=%0d", plot_addr, ea); end
        plots++;
      end
      if (done0) begin dones++; req0 = 1'b0; end
    end
    total++; if (starts != 1) begin bad++; $display("FAIL rmid_starts got=%0d want=1", starts); end
    total++; if (plots != 20) begin bad++; $display("FAIL rmid_plots got=%0d want=20", plots); end
    total++; if (dones != 1) begin bad++; $display("FAIL rmid_done got=%0d want=1", dones); end
  endtask

  task automatic drive_req(input int i, input bit r, input logic [AW-1:0] l, input logic [AW-1:0] b);
    if (i == 0) begin req0 = r; len0 = l; base0 = b; end
    else        begin req1 = r; len1 = l; base1 = b; end
  endtask

  // Transaction model: a request raised in cycle r is eligible from r+2; the arbiter
  // grants no earlier than 2 cycles after the previous done; a granted sweep of
  // len N ends with done N+2 cycles after the grant (same cycle for N=0).
  task automatic test_random();
    bit pend[2], hold[2], elig[2], ptr;
    int rise[2], cool[2];
    logic [AW-1:0] plen[2], pbase[2], ea;
    int owner, g, plots, starts, last_done, exp_done, w;
    logic [1:0] gv, dv, egv, edv;
    wait_cnt_idle(); do_reset();
    for (int i = 0; i < 2; i++) begin pend[i] = 0; hold[i] = 0; cool[i] = 0; rise[i] = 0; plen[i] = '0; pbase[i] = '0; end
    owner = -1; g = 0; plots = 0; starts = 0; last_done = -100; exp_done = 0; ptr = 0;
    for (int c = 1; c <= 900; c++) begin
      if (c > 600 && owner < 0 && !pend[0] && !pend[1]) break;
      step();
      gv = {grant1, grant0}; dv = {done1, done0};
      total++; if (busy !== (gv != 2'b00)) begin bad++; $display("FAIL rnd_busy c=%0d got=%b grant=%b", c, busy, gv); end
      if (owner < 0) begin
        for (int i = 0; i < 2; i++) elig[i] = pend[i] && (rise[i] <= c - 2);
        if (!(elig[0] || elig[1]) || c < last_done + 2) w = -1;
        else if (elig[0] && elig[1]) w = RR ? int'(ptr) : 0;
        else w = elig[1] ? 1 : 0;
        egv = (w < 0) ? 2'b00 : ((w == 1) ? 2'b10 : 2'b01);
        total++; if (gv !== egv) begin bad++; $display("FAIL rnd_grant c=%0d got=%b want=%b", c, gv, egv); end
        if (w >= 0) begin
          owner = w; g = c; plots = 0; starts = 0; pend[w] = 0;
          exp_done = g + ((plen[w] == '0) ? 0 : int'(plen[w]) + 2);
          total++; if (plot_owner !== w[0]) begin bad++; $display("FAIL rnd_owner c=%0d got=%b want=%0d", c, plot_owner, w); end
        end else begin
          total++; if ({dv, plot, cnt_start} !== 4'b0000) begin bad++; $display("FAIL rnd_idle c=%0d got=%b want=0000", c, {dv, plot, cnt_start}); end
        end
      end else begin
        egv = (owner == 1) ? 2'b10 : 2'b01;
        total++; if (gv !== egv) begin bad++; $display("FAIL rnd_hold c=%0d got=%b want=%b", c, gv, egv); end
      end
      if (owner >= 0) begin
        if (cnt_start) starts++;
        if (plot) begin
          ea = AW'(int'(pbase[owner]) + plots);
          total++; if (plot_addr !== ea) begin bad++; $display("FAIL rnd_addr c=%0d got=%0d want=%0d", c, plot_addr, ea); end
          plots++;
        end
        edv = (c == exp_done) ? ((owner == 1) ? 2'b10 : 2'b01) : 2'b00;
        total++; if (dv !== edv) begin bad++; $display("FAIL rnd_done c=%0d got=%b want=%b", c, dv, edv); end
        if (c >= exp_done) begin
          total++;
          if (plots != int'(plen[owner]) || starts != int'(plen[owner] != '0)) begin
            bad++; $display("FAIL rnd_sweep c=%0d got=%0d/%0d want=%0d/%0d", c, plots, starts, plen[owner], int'(plen[owner] != '0));
          end
          hold[owner] = 0; drive_req(owner, 1'b0, '0, '0);
          cool[owner] = 1 + int'($urandom_range(0, 3));
          last_done = c; ptr = (owner == 0); owner = -1;
        end else begin
          drive_req(owner, 1'b1, AW'($urandom), AW'($urandom));
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (!hold[i]) begin
          if (cool[i] > 0) cool[i]--;
          else if (c <= 600 && $urandom_range(0, 3) == 0) begin
            hold[i] = 1; pend[i] = 1; rise[i] = c;
            plen[i] = AW'($urandom_range(0, 9));
            pbase[i] = ($urandom_range(0, 3) == 0) ? AW'(131072 - int'($urandom_range(1, 6))) : AW'($urandom);
            drive_req(i, 1'b1, plen[i], pbase[i]);
          end
        end
      end
    end
    total++; if (owner >= 0 || pend[0] || pend[1]) begin bad++; $display("FAIL rnd_drain got=busy want=idle owner=%0d", owner); end
  endtask

  initial begin
    test_reset();
    test_single_sweep(1'b0, 17'd100, 17'd5, "basic");
    test_single_sweep(1'b0, 17'd77, 17'd1, "len1");
    test_single_sweep(1'b1, 17'd300, 17'd0, "len0");
    test_single_sweep(1'b0, 17'd131070, 17'd4, "wrap");
    test_tie();
    test_priority();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sweep_arbiter.md
SWEEP_ARBITER -- requirements
Module: sweep_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 17, width of lengths, bases and counter result (matches frame pixel-count width).
REQ-002 clk  in  1  system clock, all state on posedge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req0 / req1  in  1 each  sweep request, level, held until matching done pulse.
REQ-005 len0 / len1  in  ADDR_W each  number of addresses to sweep.
REQ-006 base0 / base1  in  ADDR_W each  first address of sweep.
REQ-007 grant0 / grant1  out  1 each  requester currently owns the counter.
REQ-008 done0 / done1  out  1 each  one-cycle completion pulse.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 cnt_start  out  1  one-cycle start pulse to the shared counter.
REQ-011 cnt_limit  out  ADDR_W  limit driven to the counter.
REQ-012 cnt_counting  in  1  counter busy flag.
REQ-013 cnt_result  in  ADDR_W  counter current value.
REQ-014 plot  out  1  valid pixel-write strobe.
REQ-015 plot_addr  out  ADDR_W  pixel address for the write.
REQ-016 plot_owner  out  1  index of the granted requester (0/1).

Function
REQ-017 FSM states SHALL be IDLE, START, ARM, RUN, DONE; one-hot or binary is free.
REQ-018 IDLE: when cnt_counting==0 and any req high, SHALL pick winner (REQ-030), latch its len/base, set grant and plot_owner next cycle; cnt_counting==1 SHALL block any grant.
REQ-019 IDLE with winner len==0 SHALL go directly to DONE; no cnt_start issued.
REQ-020 START: cnt_start SHALL be 1 for exactly one cycle; next state ARM.
REQ-021 cnt_limit SHALL equal latched len from START until return to IDLE; 0 otherwise.
REQ-022 ARM: on cnt_counting==1 -> RUN; else stay.
REQ-023 RUN: on cnt_counting==0 -> DONE.
REQ-024 plot SHALL be combinational: cnt_counting AND state in {ARM, RUN}; asserted exactly len cycles per sweep.
REQ-025 plot_addr SHALL be latched base + cnt_result, truncated modulo 2^ADDR_W (wrap allowed, no flag).
REQ-026 DONE: done of owner SHALL pulse one cycle, grant stays high that cycle, next state IDLE with grant low.
REQ-027 req/len/base changes while granted SHALL be ignored; a req still high in IDLE after DONE is a new request.
REQ-028 Loser of simultaneous requests SHALL remain pending, granted after current sweep completes.
REQ-029 Latency: req high in IDLE -> cnt_start at cycle +2 -> first plot at cycle +3 -> done at cycle len+4 (counter idle).

Reset
REQ-030a reset SHALL asynchronously force IDLE, all outputs 0, latched len/base 0, priority pointer to requester 0.
REQ-030b Reset mid-sweep SHALL abort without done; since the counter has no reset, next grant SHALL wait for cnt_counting==0 (REQ-018).

Configuration
REQ-030 Macro SWEEP_ROUND_ROBIN_EN: defined -> round-robin, pointer moves to the other requester after each DONE; undefined -> fixed priority, req0 always wins ties, no pointer register.

Verification
REQ-031 req0=1, base0=100, len0=5 -> cnt_start one cycle, plot_addr 100..104 on 5 consecutive plot cycles, done0 single pulse, grant0 low after.
REQ-032 req0 and req1 same cycle, len 3 each, twice back-to-back -> with SWEEP_ROUND_ROBIN_EN order 0,1,1,0? no: grants 0,1,0,1; without macro 0,1 then 0 first again.
REQ-033 req1=1, len1=0 -> done1 pulse 2 cycles after req, cnt_start never asserted, plot never high.
REQ-034 base0=2^17-2, len0=4 -> plot_addr 131070, 131071, 0, 1.
REQ-035 reset asserted during RUN at result 7 of len 20 -> outputs 0 immediately, no done0; req0 reasserted -> cnt_start held off until cnt_counting falls, then full 20-plot sweep.
REQ-036 len0=1 -> exactly one plot at base0, done0 pulse, return to IDLE.
